matrix_ctrl: RTL and testbench

- Initiator for the 1024x1024x32-bit matrix datapath (16 distributed RAMs, 64K words each).
- Accepts row-burst read/write commands on a valid/ready command port, streams write data in and read data out, and drives the datapath's ram_sel/a/din/we and samples its dout.
- Sits between the MAC/compute engine and the matrix datapath.

---
 rtl/matrix_pkg.sv | 25 ++
 rtl/matrix_rd_stage.sv | 37 +++
 rtl/matrix_ctrl.sv | 139 +++++++++++++
 tb/tb_matrix_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared types, constants and address helpers for the matrix controller
package matrix_pkg;

  localparam int DATA_W      = 32;
  localparam int ROW_W       = 10;
  localparam int COL_W       = 10;
  localparam int NUM_RAMS    = 16;
  localparam int RAM_ADDR_W  = 16;
  localparam int RAM_SEL_LSB = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } ctrl_state_t;

  // Upper row bits pick one of the distributed RAMs; result is always one-hot.
  function automatic logic [NUM_RAMS-1:0] row_to_sel(input logic [ROW_W-1:0] row);
    logic [NUM_RAMS-1:0] sel;
    sel = '0;
    sel[row[ROW_W-1:RAM_SEL_LSB]] = 1'b1;
    return sel;
  endfunction

endpackage

// File: rtl/matrix_rd_stage.sv
// rtl/matrix_rd_stage.sv - read output register with valid/ready capture logic
module matrix_rd_stage
  import matrix_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              capture_i,
  input  logic [DATA_W-1:0] dout_i,
  input  logic              rd_ready_i,
  output logic              can_capture_o,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] rd_data_o
);

  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;

  // The register may be refilled when empty or when its current element leaves this cycle.
  assign can_capture_o = !rd_valid_q || rd_ready_i;

  // Load a new element on capture; otherwise drain once the consumer takes it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else if (capture_i) begin
      rd_valid_q <= 1'b1;
      rd_data_q  <= dout_i;
    end else if (rd_ready_i) begin
      rd_valid_q <= 1'b0;
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;

endmodule

// File: rtl/matrix_ctrl.sv
// rtl/matrix_ctrl.sv - row-burst read/write initiator for the banked matrix datapath
module matrix_ctrl
  import matrix_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST_L,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ROW_W-1:0]      cmd_row,
  input  logic [COL_W-1:0]      cmd_col,
  input  logic [COL_W-1:0]      cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_W-1:0]     wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  done,
  output logic [NUM_RAMS-1:0]   ram_sel,
  output logic [RAM_ADDR_W-1:0] a,
  output logic [DATA_W-1:0]     din,
  output logic [NUM_RAMS-1:0]   we,
  input  logic [DATA_W-1:0]     dout
);

  ctrl_state_t                state_q;
  logic [RAM_SEL_LSB-1:0]     row_lo_q;
  logic [COL_W-1:0]           col_q;
  logic [COL_W-1:0]           rem_q;
  logic [NUM_RAMS-1:0]        ram_sel_q;
  logic [RAM_ADDR_W-1:0]      a_q;
  logic                       cmd_ready_q;
  logic                       wr_ready_q;
  logic                       done_q;
  logic                       rd_go_q;

  logic                       wr_fire;
  logic                       rd_capture;
  logic                       rd_can_capture;
  logic [COL_W-1:0]           col_d;

  // Column arithmetic wraps at 1024 so a burst stays within its row.
  assign col_d      = col_q + COL_W'(1);
  assign wr_fire    = (state_q == WRITE) && wr_valid;
  // rd_go_q holds off the first capture one cycle so dout settles after the address loads.
  assign rd_capture = (state_q == READ) && rd_go_q && rd_can_capture;

  // Burst sequencer: command decode, address generation, beat counting and done pulse.
  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      state_q     <= IDLE;
      row_lo_q    <= '0;
      col_q       <= '0;
      rem_q       <= '0;
      ram_sel_q   <= NUM_RAMS'(1);
      a_q         <= '0;
      cmd_ready_q <= 1'b1;
      wr_ready_q  <= 1'b0;
      done_q      <= 1'b0;
      rd_go_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            row_lo_q    <= cmd_row[RAM_SEL_LSB-1:0];
            col_q       <= cmd_col;
            rem_q       <= cmd_len;
            ram_sel_q   <= row_to_sel(cmd_row);
            a_q         <= {cmd_row[RAM_SEL_LSB-1:0], cmd_col};
            cmd_ready_q <= 1'b0;
            rd_go_q     <= 1'b0;
            if (cmd_write) begin
              state_q    <= WRITE;
              wr_ready_q <= 1'b1;
            end else begin
              state_q    <= READ;
            end
          end
        end
        WRITE: begin
          if (wr_fire) begin
            col_q <= col_d;
            a_q   <= {row_lo_q, col_d};
            if (rem_q == '0) begin
              state_q     <= IDLE;
              wr_ready_q  <= 1'b0;
              cmd_ready_q <= 1'b1;
              done_q      <= 1'b1;
            end else begin
              rem_q <= rem_q - COL_W'(1);
            end
          end
        end
        READ: begin
          rd_go_q <= 1'b1;
          if (rd_capture) begin
            col_q <= col_d;
            a_q   <= {row_lo_q, col_d};
            if (rem_q == '0) begin
              state_q     <= IDLE;
              cmd_ready_q <= 1'b1;
              rd_go_q     <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              rem_q <= rem_q - COL_W'(1);
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
          wr_ready_q  <= 1'b0;
        end
      endcase
    end
  end

  matrix_rd_stage u_rd_stage (
    .clk_i         (CLK),
    .rst_ni        (RST_L),
    .capture_i     (rd_capture),
    .dout_i        (dout),
    .rd_ready_i    (rd_ready),
    .can_capture_o (rd_can_capture),
    .rd_valid_o    (rd_valid),
    .rd_data_o     (rd_data)
  );

  assign cmd_ready = cmd_ready_q;
  assign wr_ready  = wr_ready_q;
  assign done      = done_q;
  assign ram_sel   = ram_sel_q;
  assign a         = a_q;
  assign din       = wr_data;
  assign we        = wr_fire ? ram_sel_q : '0;

endmodule

// File: tb/tb_matrix_ctrl.sv
// tb/tb_matrix_ctrl.sv - randomized self-checking bench for matrix_ctrl
module tb_matrix_ctrl;
  import matrix_pkg::*;

  logic                  CLK = 1'b0;
  logic                  RST_L;
  logic                  cmd_valid, cmd_ready, cmd_write;
  logic [ROW_W-1:0]      cmd_row;
  logic [COL_W-1:0]      cmd_col, cmd_len;
  logic                  wr_valid, wr_ready;
  logic [DATA_W-1:0]     wr_data;
  logic                  rd_valid, rd_ready;
  logic [DATA_W-1:0]     rd_data;
  logic                  done;
  logic [NUM_RAMS-1:0]   ram_sel, we;
  logic [RAM_ADDR_W-1:0] a;
  logic [DATA_W-1:0]     din, dout;

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] ref_mem [int];
  logic [DATA_W-1:0] dp_mem [0:(1<<20)-1];

  always #5 CLK = ~CLK;

  matrix_ctrl dut (
    .CLK(CLK), .RST_L(RST_L),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .done(done), .ram_sel(ram_sel), .a(a), .din(din), .we(we), .dout(dout)
  );

  function automatic logic [3:0] sel_idx(input logic [15:0] s);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < 16; i++) if (s[i]) r = 4'(i);
    return r;
  endfunction

  assign dout = dp_mem[{sel_idx(ram_sel), a}];
  always @(posedge CLK) if (we != '0) dp_mem[{sel_idx(we), a}] <= din;

  task automatic issue_cmd(input bit wr, input int row, input int col, input int len, output bit ok);
    int n;
    n = 0;
    @(negedge CLK);
    cmd_valid = 1'b1; cmd_write = wr;
    cmd_row = 10'(row); cmd_col = 10'(col); cmd_len = 10'(len);
    #1;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge CLK); #1; n++;
    end
    ok = (cmd_ready === 1'b1);
    @(negedge CLK);
    cmd_valid = 1'b0;
  endtask

  task automatic run_write(input int row, input int col, input int len, input int gap_mode,
                           input bit seq, input logic [31:0] data0,
                           output int cycles, output int we_cnt);
    int beat, cyc, done_cnt, exp_a;
    bit ok, v;
    logic [15:0] exp_sel;
    beat = 0; cyc = 0; done_cnt = 0; we_cnt = 0;
    exp_sel = 16'(1) << (row / 64);
    issue_cmd(1'b1, row, col, len, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wr_cmd_accept row=%0d got cmd_ready=%b need 1", row, cmd_ready); end
    while (beat <= len && cyc < 4000) begin
      v = (gap_mode == 0) ? 1'b1 : (gap_mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      wr_valid = v;
      wr_data = seq ? data0 + 32'(beat) : $urandom;
      #1;
      if (done === 1'b1) done_cnt++;
      if (v) begin
        exp_a = (row % 64) * 1024 + (col + beat) % 1024;
        checks++;
        if (we !== exp_sel || a !== 16'(exp_a) || din !== wr_data || wr_ready !== 1'b1 || cmd_ready !== 1'b0) begin
          errors++;
          $display("FAIL write_beat %0d got we=%h a=%h din=%h wr_ready=%b cmd_ready=%b need we=%h a=%h din=%h 1 0",
                   beat, we, a, din, wr_ready, cmd_ready, exp_sel, 16'(exp_a), wr_data);
        end
        ref_mem[row * 1024 + (col + beat) % 1024] = wr_data;
        beat++; we_cnt++;
      end else begin
        checks++;
        if (we !== '0) begin errors++; $display("FAIL write_gap_we got %h need 0", we); end
      end
      @(negedge CLK); cyc++;
    end
    wr_valid = 1'b0;
    #1;
    checks++; if (beat != len + 1) begin errors++; $display("FAIL write_timeout got %0d beats need %0d", beat, len + 1); end
    checks++;
    if (done !== 1'b1 || done_cnt != 0 || cmd_ready !== 1'b1 || we !== '0) begin
      errors++;
      $display("FAIL write_done got done=%b early=%0d cmd_ready=%b we=%h need 1 0 1 0", done, done_cnt, cmd_ready, we);
    end
    @(negedge CLK); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_width got %b need 0", done); end
    cycles = cyc;
  endtask

  task automatic run_read(input int row, input int col, input int len, input int mode, input bit timing);
    logic [31:0] exp_q[$];
    logic [31:0] prev_data;
    bit ok, r, prev_stall;
    int idx, cyc, first, last, done_cyc, done_cnt;
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i <= len; i++) exp_q.push_back(ref_mem[row * 1024 + (col + i) % 1024]);
    idx = 0; cyc = 0; first = -1; last = -1; done_cyc = -1; done_cnt = 0;
    prev_stall = 1'b0; prev_data = '0;
    issue_cmd(1'b0, row, col, len, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rd_cmd_accept got cmd_ready=%b need 1", cmd_ready); end
    while (idx <= len && cyc < 4000) begin
      r = (mode == 0) ? 1'b1 : (mode == 1) ? pat[cyc % 4] : 1'($urandom_range(0, 1));
      rd_ready = r;
      #1;
      if (prev_stall) begin
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== prev_data) begin
          errors++; $display("FAIL rd_hold got valid=%b data=%h need 1 %h", rd_valid, rd_data, prev_data);
        end
      end
      if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
      if (rd_valid === 1'b1 && r) begin
        checks++;
        if (rd_data !== exp_q[idx]) begin
          errors++; $display("FAIL rd_data[%0d] got %h need %h", idx, rd_data, exp_q[idx]);
        end
        if (first < 0) first = cyc;
        last = cyc; idx++;
      end
      prev_stall = (rd_valid === 1'b1) && !r;
      prev_data = rd_data;
      @(negedge CLK); cyc++;
    end
    rd_ready = 1'b0;
    #1;
    checks++;
    if (idx != len + 1 || done_cnt != 1 || rd_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rd_end got beats=%0d dones=%0d rd_valid=%b cmd_ready=%b need %0d 1 0 1",
               idx, done_cnt, rd_valid, cmd_ready, len + 1);
    end
    if (timing) begin
      checks++;
      if (first != 2 || last != 2 + len || done_cyc != last) begin
        errors++;
        $display("FAIL rd_timing got first=%0d last=%0d done=%0d need 2 %0d %0d", first, last, done_cyc, 2 + len, 2 + len);
      end
    end
  endtask

  task automatic test_reset();
    RST_L = 1'b0; cmd_valid = 0; cmd_write = 0; cmd_row = 0; cmd_col = 0; cmd_len = 0;
    wr_valid = 0; wr_data = 0; rd_ready = 0;
    repeat (3) @(negedge CLK);
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || wr_ready !== 1'b0 || rd_valid !== 1'b0 || rd_data !== '0 || done !== 1'b0 ||
        ram_sel !== 16'h0001 || a !== 16'h0000 || we !== 16'h0000) begin
      errors++;
      $display("FAIL reset_state got cr=%b wr=%b rv=%b rd=%h d=%b sel=%h a=%h we=%h need 1 0 0 0 0 0001 0000 0000",
               cmd_ready, wr_ready, rd_valid, rd_data, done, ram_sel, a, we);
    end
    @(negedge CLK); RST_L = 1'b1;
  endtask

  task automatic test_single();
    int cy, wc;
    run_write(5, 7, 0, 0, 1'b1, 32'hDEADBEEF, cy, wc);
    checks++; if (wc != 1) begin errors++; $display("FAIL single_we_count got %0d need 1", wc); end
    run_read(5, 7, 0, 0, 1'b1);
  endtask

  task automatic test_burst_read();
    int cy, wc;
    run_write(70, 0, 7, 0, 1'b1, 32'd0, cy, wc);
    run_read(70, 0, 7, 0, 1'b1);
  endtask

  task automatic test_backpressure();
    run_read(70, 0, 7, 1, 1'b0);
  endtask

  task automatic test_col_wrap();
    int cy, wc;
    run_write(1023, 1022, 3, 0, 1'b0, 32'd0, cy, wc);
    run_read(1023, 1022, 3, 2, 1'b0);
  endtask

  task automatic test_write_gaps();
    int cy, wc;
    run_write(300, 40, 2, 1, 1'b0, 32'd0, cy, wc);
    checks++;
    if (cy != 5 || wc != 3) begin errors++; $display("FAIL write_gaps got cycles=%0d we=%0d need 5 3", cy, wc); end
    run_read(300, 40, 2, 0, 1'b1);
  endtask

  task automatic test_random();
    int row, col, len, cy, wc;
    for (int k = 0; k < 6; k++) begin
      row = $urandom_range(0, 1023); col = $urandom_range(0, 1023); len = $urandom_range(0, 15);
      run_write(row, col, len, 2, 1'b0, 32'd0, cy, wc);
      run_read(row, col, len, 2, 1'b0);
    end
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    int got, cyc;
    issue_cmd(1'b0, 70, 0, 7, ok);
    got = 0; cyc = 0; rd_ready = 1'b1;
    while (got < 3 && cyc < 50) begin
      #1; if (rd_valid === 1'b1) got++;
      @(negedge CLK); cyc++;
    end
    RST_L = 1'b0;
    #1;
    checks++;
    if (got != 3 || rd_valid !== 1'b0 || we !== '0 || ram_sel !== 16'h0001 || cmd_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_read got beats=%0d rv=%b we=%h sel=%h cr=%b done=%b need 3 0 0 0001 1 0",
               got, rd_valid, we, ram_sel, cmd_ready, done);
    end
    @(negedge CLK); RST_L = 1'b1; rd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (cmd_ready !== 1'b1 || rd_valid !== 1'b0 || done !== 1'b0) begin
        errors++; $display("FAIL post_reset_idle got cr=%b rv=%b done=%b need 1 0 0", cmd_ready, rd_valid, done);
      end
      @(negedge CLK);
    end
    issue_cmd(1'b1, 200, 5, 7, ok);
    wr_valid = 1'b1;
    repeat (2) begin wr_data = $urandom; @(negedge CLK); end
    RST_L = 1'b0;
    #1;
    checks++;
    if (we !== '0 || wr_ready !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_mid_write got we=%h wr_ready=%b cr=%b need 0 0 1", we, wr_ready, cmd_ready);
    end
    @(negedge CLK); RST_L = 1'b1;
    #1;
    checks++;
    if (we !== '0) begin errors++; $display("FAIL write_after_reset got we=%h need 0", we); end
    wr_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst_read();
    test_backpressure();
    test_col_wrap();
    test_write_gaps();
    test_random();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
